// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM state encoding, load/store size codes and block geometry.
package dcache_pkg;

  localparam int OFFSET_W = 4;
  localparam int BLOCK_W  = 128;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dcache_load_align.sv
// Picks a byte, half or word out of a 32-bit cache word and sign/zero extends it.
module dcache_load_align
  import dcache_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_sel,
  input  logic [2:0]  fun_3,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[{byte_sel, 3'b000} +: 8];
    // Halfword select ignores byte_sel[0]; misaligned halves read the aligned one.
    sel_half = byte_sel[1] ? word[31:16] : word[15:0];
    case (fun_3)
      F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    data = {{16{sel_half[15]}}, sel_half};
      F3_BU:   data = {24'h0, sel_byte};
      F3_HU:   data = {16'h0, sel_half};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache at the MEM stage.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int NUM_LINES       = 8,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        address,
  input  logic [31:0]        writedata,
  input  logic [2:0]         fun_3,
  output logic [31:0]        readdata,
  output logic               busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [27:0]        mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait,
`ifdef DCACHE_STATS_EN
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count,
`endif
  output logic [1:0]         fsm_state
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 32 - OFFSET_W - IDX_W;
  localparam int LINE_W = WORDS_PER_BLOCK * 32;

  // Memory handshake: mem_read/mem_write stays high, with address and data stable,
  // until the first cycle mem_busywait is low; that rising edge completes the transfer.
  state_t             state;
  logic [LINE_W-1:0]  data_arr [NUM_LINES];
  logic [TAG_W-1:0]   tag_arr  [NUM_LINES];
  logic [NUM_LINES-1:0] valid, dirty;
  logic [27:0]        miss_blk;
  logic [LINE_W-1:0]  fill_buf;

  logic [IDX_W-1:0]   idx, miss_idx;
  logic [TAG_W-1:0]   tag, miss_tag;
  logic               req, hit;
  logic [LINE_W-1:0]  cur_line, new_line;
  logic [31:0]        cur_word, aligned, rep, merged_word;
  logic [3:0]         be;

  assign idx       = address[OFFSET_W +: IDX_W];
  assign tag       = address[31 -: TAG_W];
  assign miss_idx  = miss_blk[IDX_W-1:0];
  assign miss_tag  = miss_blk[27 -: TAG_W];
  assign req       = read || write;
  assign hit       = valid[idx] && (tag_arr[idx] == tag) && (state == IDLE);
  assign busywait  = req && !hit;
  assign cur_line  = data_arr[idx];
  assign cur_word  = cur_line[{address[3:2], 5'b00000} +: 32];
  assign fsm_state = state;

  dcache_load_align u_align (
    .word     (cur_word),
    .byte_sel (address[1:0]),
    .fun_3    (fun_3),
    .data     (aligned)
  );

  // A simultaneous read and write is served as a write, so no load data.
  assign readdata = (read && !write && hit) ? aligned : 32'h0;

  always_comb begin
    case (fun_3)
      F3_B, F3_BU: begin
        be  = 4'b0001 << address[1:0];
        rep = {4{writedata[7:0]}};
      end
      F3_H, F3_HU: begin
        be  = address[1] ? 4'b1100 : 4'b0011;
        rep = {2{writedata[15:0]}};
      end
      default: begin
        be  = 4'b1111;
        rep = writedata;
      end
    endcase
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged_word[i*8 +: 8] = rep[i*8 +: 8];
    end
    new_line = cur_line;
    new_line[{address[3:2], 5'b00000} +: 32] = merged_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      miss_blk      <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            miss_blk <= address[31:4];
            if (valid[idx] && dirty[idx]) begin
              state         <= WRITEBACK;
              mem_write     <= 1'b1;
              mem_address   <= {tag_arr[idx], idx};
              mem_writedata <= data_arr[idx];
            end else begin
              state       <= FETCH;
              mem_read    <= 1'b1;
              mem_address <= address[31:4];
            end
          end else if (write && hit) begin
            dirty[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (!mem_busywait) begin
            state       <= FETCH;
            mem_write   <= 1'b0;
            mem_read    <= 1'b1;
            mem_address <= miss_blk;
          end
        end
        FETCH: begin
          if (!mem_busywait) begin
            state    <= UPDATE;
            mem_read <= 1'b0;
          end
        end
        UPDATE: begin
          valid[miss_idx] <= 1'b1;
          dirty[miss_idx] <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage is never cleared; only the valid/dirty bits above reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == FETCH && !mem_busywait) fill_buf <= mem_readdata;
      if (state == UPDATE) begin
        data_arr[miss_idx] <= fill_buf;
        tag_arr[miss_idx]  <= miss_tag;
      end else if (write && hit) begin
        data_arr[idx] <= new_line;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (req && hit) hit_count <= hit_count + 32'd1;
      if (state == IDLE && req && !hit) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: directed scenarios then random traffic checked
// against a byte-addressed memory image and a tag-only residency model.
module tb_dcache_responder;
  import dcache_pkg::*;

  logic         clk = 1'b0;
  logic         reset, read, write;
  logic [31:0]  address, writedata;
  logic [2:0]   fun_3;
  logic [31:0]  readdata;
  logic         busywait, mem_read, mem_write, mem_busywait;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata, mem_readdata;
  logic [1:0]   fsm_state;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  dcache_responder dut (
    .clk           (clk),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .fun_3         (fun_3),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait),
`ifdef DCACHE_STATS_EN
    .hit_count     (hit_count),
    .miss_count    (miss_count),
`endif
    .fsm_state     (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- main memory (64 blocks) ----------------
  logic [31:0]  seed;
  int           mem_wait = 0;
  int           mem_cnt;
  bit           mem_wflag [0:63];
  logic [127:0] mem_wdata [0:63];
  bit           both_seen;
  logic [156:0] xfer_log [0:1023];
  int           xfer_n;

  function automatic logic [127:0] init_blk(input int b, input logic [31:0] s);
    logic [127:0] r;
    if (b == 1) return 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    for (int i = 0; i < 4; i++)
      r[i*32 +: 32] = (32'(b) * 32'h9E3779B9) ^ (32'(i) * 32'h85EBCA6B) ^ s;
    return r;
  endfunction

  assign mem_busywait = (mem_read || mem_write) && (mem_cnt < mem_wait);
  assign mem_readdata = mem_wflag[mem_address[5:0]] ? mem_wdata[mem_address[5:0]]
                                                    : init_blk(int'(mem_address[5:0]), seed);

  always @(posedge clk) begin
    if (mem_read && mem_write) both_seen <= 1'b1;
    if (mem_read || mem_write) begin
      if (mem_cnt < mem_wait) mem_cnt <= mem_cnt + 1;
      else begin
        mem_cnt <= 0;
        if (mem_write) begin
          mem_wflag[mem_address[5:0]] <= 1'b1;
          mem_wdata[mem_address[5:0]] <= mem_writedata;
        end
        if (xfer_n < 1024)
          xfer_log[xfer_n] <= {mem_write, mem_address, mem_write ? mem_writedata : 128'h0};
        xfer_n <= xfer_n + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]   ref_b [0:1023];
  bit           m_valid [0:7];
  bit           m_dirty [0:7];
  int           m_tag [0:7];
  int           exp_hits, exp_misses, xfer_rp;
  logic [156:0] exp_q [$];

  task automatic check(input string name, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input int a, input logic [2:0] f3);
    int base = a & ~3;
    int h = base + (a & 2);
    logic [7:0]  bb = ref_b[a];
    logic [15:0] hh = {ref_b[h+1], ref_b[h]};
    logic [31:0] ww = {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
    case (f3)
      3'b000:  return {{24{bb[7]}}, bb};
      3'b001:  return {{16{hh[15]}}, hh};
      3'b100:  return {24'h0, bb};
      3'b101:  return {16'h0, hh};
      default: return ww;
    endcase
  endfunction

  task automatic ref_store(input int a, input logic [31:0] wd, input logic [2:0] f3);
    int base = a & ~3;
    int h = base + (a & 2);
    if (f3 == 3'b000) ref_b[a] = wd[7:0];
    else if (f3 == 3'b001) begin
      ref_b[h] = wd[7:0];
      ref_b[h+1] = wd[15:8];
    end else
      for (int k = 0; k < 4; k++) ref_b[base+k] = wd[k*8 +: 8];
  endtask

  function automatic logic [127:0] ref_block(input int b);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = ref_b[b*16 + k];
    return r;
  endfunction

  task automatic ref_reload();
    logic [127:0] blk;
    for (int b = 0; b < 64; b++) begin
      blk = mem_wflag[b] ? mem_wdata[b] : init_blk(b, seed);
      for (int k = 0; k < 16; k++) ref_b[b*16 + k] = blk[k*8 +: 8];
    end
  endtask

  // ---------------- driver ----------------
  task automatic access(input bit rd, input bit wr, input int a, input logic [31:0] wd,
                        input logic [2:0] f3, output int busy, output logic [31:0] rdata);
    int idx, tg, exp_busy;
    logic [31:0]  exp_rd;
    logic [156:0] e;
    idx = (a >> 4) % 8;
    tg = a >> 7;
    exp_busy = 0;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      exp_busy = 3 + mem_wait;
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_q.push_back({1'b1, 28'(m_tag[idx]*8 + idx), ref_block(m_tag[idx]*8 + idx)});
        exp_busy += 1 + mem_wait;
      end
      exp_q.push_back({1'b0, 28'(a >> 4), 128'h0});
      m_valid[idx] = 1'b1;
      m_tag[idx] = tg;
      m_dirty[idx] = 1'b0;
      exp_misses++;
    end
    exp_hits++;
    exp_rd = (rd && !wr) ? ref_load(a, f3) : 32'h0;
    if (wr) begin
      ref_store(a, wd, f3);
      m_dirty[idx] = 1'b1;
    end

    @(negedge clk);
    read = rd; write = wr; address = 32'(a); writedata = wd; fun_3 = f3;
    #1;
    busy = 0;
    while (busywait && busy < 200) begin
      busy++;
      @(negedge clk);
      #1;
    end
    rdata = readdata;
    check("busy_cycles", busy, exp_busy);
    check("readdata", rdata, exp_rd);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (xfer_rp < xfer_n) begin
        check("mem_xfer", xfer_log[xfer_rp], e);
        xfer_rp++;
      end else begin
        check("mem_xfer_missing", xfer_n, xfer_rp + 1);
      end
    end
    check("mem_xfer_count", xfer_n, xfer_rp);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int busy;
    logic [31:0] rd;
    int r, a;
    logic [2:0] f3;
    bit rdb, wrb;

    seed = $urandom;
    reset = 1'b1; read = 1'b0; write = 1'b0;
    address = 32'h0; writedata = 32'h0; fun_3 = 3'b010;
    ref_reload();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_state", fsm_state, IDLE);
    check("rst_busywait", busywait, 1'b0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_address", mem_address, 28'h0);
    check("rst_mem_writedata", mem_writedata, 128'h0);
    check("rst_readdata", readdata, 32'h0);

    // Cold read miss, zero-wait memory
    mem_wait = 0;
    access(1, 0, 32'h10, 32'h0, 3'b010, busy, rd);
    check("t1_busy3", busy, 3);
    check("t1_word", rd, 32'hAAAAAAAA);

    // Byte loads with sign and zero extension
    access(0, 1, 32'h10, 32'h80FF1234, 3'b010, busy, rd);
    check("t2_sw_hit", busy, 0);
    access(1, 0, 32'h13, 32'h0, 3'b000, busy, rd);
    check("t2_lb", rd, 32'hFFFFFF80);
    access(1, 0, 32'h13, 32'h0, 3'b100, busy, rd);
    check("t2_lbu", rd, 32'h00000080);

    // Halfword store merge
    access(0, 1, 32'h12, 32'h0000BEEF, 3'b001, busy, rd);
    check("t3_sh_hit", busy, 0);
    access(1, 0, 32'h10, 32'h0, 3'b010, busy, rd);
    check("t3_merged", rd, 32'hBEEF1234);

    // Dirty eviction with slow memory
    mem_wait = 2;
    access(1, 0, 32'h90, 32'h0, 3'b010, busy, rd);
    check("t4_busy", busy, 8);
    check("t4_wb_block", mem_wdata[1], 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_BEEF1234);

    // Reset during FETCH abandons the transfer
    mem_wait = 4;
    @(negedge clk);
    read = 1'b1; write = 1'b0; address = 32'h10; fun_3 = 3'b010;
    @(negedge clk);
    #1;
    check("t5_fetch_mem_read", mem_read, 1'b1);
    check("t5_miss_readdata", readdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_state_idle", fsm_state, IDLE);
    check("t5_mem_read_off", mem_read, 1'b0);
    check("t5_still_miss", busywait, 1'b1);
    read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
    @(negedge clk);
    xfer_rp = xfer_n;
    ref_reload();
    mem_wait = 0;
    access(1, 0, 32'h10, 32'h0, 3'b010, busy, rd);
    check("t5_remiss_busy", busy, 3);
    access(1, 0, 32'h14, 32'h0, 3'b010, busy, rd);
    access(1, 0, 32'h18, 32'h0, 3'b010, busy, rd);
    access(1, 0, 32'h1C, 32'h0, 3'b010, busy, rd);
`ifdef DCACHE_STATS_EN
    check("t6_miss_count", miss_count, 32'd1);
    check("t6_hit_count", hit_count, 32'd4);
`endif

    // Random traffic over 64 blocks sharing 8 lines
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 1023);
      rdb = (r < 6) || (r == 9);
      wrb = (r >= 6);
      f3 = wrb ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      mem_wait = $urandom_range(0, 2);
      access(rdb, wrb, a, $urandom, f3, busy, rd);
    end

`ifdef DCACHE_STATS_EN
    check("final_hit_count", hit_count, 32'(exp_hits));
    check("final_miss_count", miss_count, 32'(exp_misses));
`endif
    check("mem_rw_exclusive", both_seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Write-back, write-allocate, direct-mapped data cache; sits at the memory-stage end of the EX/MEM pipeline register.
- Accepts read/write requests, address, store data and fun_3 from that register and returns read data.
- Raises busywait to stall the pipeline while a miss is serviced against main memory through a block-wide read/write handshake.

Parameters:
NUM_LINES, 8, number of cache lines; power of two, ≥2.
WORDS_PER_BLOCK, 4, 32-bit words per line; fixed at 4 (offset = 4 bits).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- read  in  1  load request from the pipeline register.
- write  in  1  store request from the pipeline register.
- address  in  32  byte address (ALU result).
- writedata  in  32  store data (register-2 value).
- fun_3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- readdata  out  32  aligned and extended load result; combinational.
- busywait  out  1  stall request to the pipeline; combinational.
- mem_read  out  1  block fetch request.
- mem_write  out  1  block write-back request.
- mem_address  out  28  block address (byte address [31:4]).
- mem_writedata  out  128  victim block.
- mem_readdata  in  128  fetched block.
- mem_busywait  in  1  main memory busy; the transfer completes on the first cycle this is low while a request is asserted.

Behaviour:
- Address split:
  - offset = address[3:0]; word = [3:2], byte = [1:0].
  - index = next log2(NUM_LINES) bits.
  - tag = remaining upper bits.
- hit = valid[index] && tag match && state==IDLE.
- busywait = (read||write) && !hit. Deasserted in the same cycle as a hit.
- Read hit:
  - readdata valid combinationally in the same cycle.
  - B/BU select the byte by address[1:0]; H/HU select the half by address[1]; address[0] ignored for H.
  - B and H are sign-extended; BU and HU are zero-extended.
  - fun_3 values 011, 110 and 111 return the full word.
  - readdata = 0 when not (read && hit).
- Write hit:
  - At the posedge, merge the byte, half or word into the line and set dirty.
  - Other bytes are unchanged.
- read && write together: treated as write; readdata = 0.
- FSM states and transitions:
  - IDLE → WRITEBACK on a miss with a dirty victim.
  - IDLE → FETCH on a miss with a clean or invalid victim.
  - WRITEBACK: mem_write=1, mem_address={victim tag,index}, mem_writedata=victim block. Exits to FETCH when mem_busywait=0.
  - FETCH: mem_read=1, mem_address=address[31:4]. Exits to UPDATE when mem_busywait=0.
  - UPDATE: write mem_readdata into the line, valid=1, dirty=0, tag updated; → IDLE.
  - In IDLE the request now hits and is served; the write is merged and dirty set at that edge.
- Miss latencies:
  - Clean miss, zero-wait memory: busywait high for 3 cycles (IDLE-miss, FETCH, UPDATE); hit on the 4th cycle.
  - Dirty miss adds at least 1 WRITEBACK cycle.
- mem_read and mem_write are never both high; both are 0 in IDLE and UPDATE.
- Request dropped mid-miss (pipeline flushed): the FSM still completes the current transfer, then returns to IDLE.
- Reset:
  - State → IDLE; all valid and dirty bits cleared.
  - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
  - Any in-flight memory transfer is abandoned.
  - Data and tag arrays are not cleared.

Optional Feature:
DCACHE_STATS_EN:
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments once per cycle in which (read||write)&&hit.
  - miss_count increments on each IDLE→WRITEBACK/FETCH transition.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - state encoding (IDLE, WRITEBACK, FETCH, UPDATE);
  - fun_3 codes F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - OFFSET_W=4, BLOCK_W=128.
- Sub-module dcache_load_align: combinational word → byte/half select plus sign/zero extension. Reused by the store byte-enable merge logic only through shared fun_3 codes.

Test Plan:
1. Reset, then read address 0x00000010, fun_3=010, memory returns block 0x...DDDDCCCCBBBBAAAA with mem_busywait=0 → busywait high for 3 cycles, mem_read=1 and mem_address=0x0000001 during FETCH, then readdata=0xAAAAAAAA.
2. Read hit 0x00000013 with fun_3=000 on word 0x80FF1234 → readdata=0xFFFFFF80; same address with fun_3=100 → 0x00000080.
3. Write 0x00000012, fun_3=001, data 0x0000BEEF to a resident line → busywait=0; a next read of word 0x10 returns 0xBEEFxxxx with the low half unchanged; dirty set.
4. Dirty line at index 1; read 0x00000090 (same index, different tag) → WRITEBACK with mem_write=1, mem_address=0x0000001 and the merged block, then FETCH with mem_address=0x0000009; busywait held through both; mem_busywait=1 for 2 cycles extends each phase.
5. Assert reset during FETCH → next cycle state=IDLE, mem_read=0; read of 0x10 misses again.
6. With DCACHE_STATS_EN, do 1 miss then 3 hits → miss_count=1, hit_count=4 (the post-fill hit counts).
